// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: sequences multi-byte add/subtract through an external
// 8-bit ripple-carry adder, LSB byte first, chaining the carry in a register.
// Operands arrive on a valid/ready handshake; the assembled result, carry-out
// and signed overflow leave on a second valid/ready handshake.
module byte_serial_add_ctrl #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   input  logic                cin,
   input  logic                sub,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] result,
   output logic                cout,
   output logic                overflow
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned CW = $clog2(NBYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_sr, b_sr, res_r;
   logic            carry, cout_r, ovf_r;
   logic [CW-1:0]   cnt;
   logic            accept, last;

   // in_ready is held low while reset is asserted so every output reads 0 in reset
   assign in_ready  = (state == IDLE) && rst_n;
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == CW'(NBYTES - 1));
   assign out_valid = (state == DONE);
   assign result    = res_r;
   assign cout      = cout_r;
   assign overflow  = ovf_r;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // adder drive: low bytes of the shift registers during RUN, zero otherwise
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_sr[7:0];
         add_b   = b_sr[7:0];
         add_cin = carry;
      end
   end

   // operand capture, byte shifting, carry chaining and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sr  <= op_a;
                  b_sr  <= sub ? ~op_b : op_b;
                  carry <= sub | cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               carry <= add_cout;
               res_r <= {add_sum, res_r[W-1:8]};
               a_sr  <= a_sr >> 8;
               b_sr  <= b_sr >> 8;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  cout_r <= add_cout;
                  ovf_r  <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl with a behavioural 8-bit adder
// attached and a scoreboard of expected results.
module tb_byte_serial_add_ctrl;

   localparam int unsigned NBYTES = 4;
   localparam int unsigned W      = 8 * NBYTES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  op_a = '0, op_b = '0;
   logic          cin = 1'b0, sub = 1'b0;
   logic [7:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          cout, overflow;
   logic [8:0]    add_full;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   // behavioural 8-bit ripple-carry adder
   assign add_full = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
   assign add_sum  = add_full[7:0];
   assign add_cout = add_full[8];

   byte_serial_add_ctrl #(.NBYTES(NBYTES)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout), .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic s);
      logic [W-1:0] bx;
      logic [W:0]   full;
      exp_t         e;
      bx   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bx} + (W+1)'(s ? 1'b1 : c);
      e.r  = full[W-1:0];
      e.c  = full[W];
      e.o  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   // scoreboard: compare each result as it is handed off downstream
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("result", 64'(result), 64'(e.r));
            chk("cout", 64'(cout), 64'(e.c));
            chk("overflow", 64'(overflow), 64'(e.o));
         end
      end
   end

   // present an operand and hold it until accepted; returns 1 ns after the accept edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
      int n = 0;
      op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 64'(in_ready), 64'd1);
      q.push_back(model(a, b, c, s));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // scramble inputs: only the accept edge may sample them
      op_a = W'($urandom); op_b = W'($urandom); cin = ~c; sub = ~s;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_cout_ovf", 64'({cout, overflow}), 64'd0);
      chk("rst_adder", 64'({add_a, add_b, add_cin}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // add with latency check
      send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      for (int unsigned k = 1; k <= NBYTES; k++) begin
         @(posedge clk); #1;
         chk($sformatf("latency_%0d", k), 64'(out_valid), 64'(k == NBYTES));
      end
      drain();

      // add wrap with carry-in, observe add_cin per byte
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      for (int unsigned k = 0; k < NBYTES; k++) begin
         chk($sformatf("wrap_add_cin_%0d", k), 64'(add_cin), 64'd1);
         @(posedge clk); #1;
      end
      drain();

      // signed overflow
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
      drain();

      // subtract with borrow, cin ignored
      send(32'h00000005, 32'h00000007, 1'b1, 1'b1);
      drain();

      // backpressure
      out_ready = 1'b0;
      send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
      for (int n = 0; n < 50 && !out_valid; n++) @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         op_a = W'($urandom);
         @(negedge clk);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_result", 64'(result), 64'h100);
         chk("bp_hold_flags", 64'({cout, overflow}), 64'd0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_handshake_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_after_valid", 64'(out_valid), 64'd0);
      chk("bp_after_in_ready", 64'(in_ready), 64'd1);
      chk("bp_sb_empty", 64'(q.size()), 64'd0);
      send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
      drain();

      // reset mid-RUN after two bytes
      send(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_run_add_a", 64'(add_a), 64'hAA);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_flags", 64'({out_valid, cout, overflow}), 64'd0);
      chk("abort_adder", 64'({add_a, add_b, add_cin}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      for (int unsigned k = 0; k < NBYTES + 4; k++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", 64'(out_valid), 64'd0);
      end
      send(32'h00000001, 32'h00000001, 1'b0, 1'b1);
      drain();

      // random mix of add and subtract
      for (int i = 0; i < 12; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
